// File: rtl/coh_pkg.sv
// rtl/coh_pkg.sv - shared encodings for the L1 coherence agent
package coh_pkg;

  localparam logic [1:0] COH_I = 2'd0;
  localparam logic [1:0] COH_S = 2'd1;
  localparam logic [1:0] COH_M = 2'd2;

  localparam logic [1:0] REQ_READ  = 2'd0;
  localparam logic [1:0] REQ_WRITE = 2'd1;

  localparam int LINE_OFF = 6;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT
  } fsm_state_t;

endpackage

// File: rtl/coh_line_state_array.sv
// rtl/coh_line_state_array.sv - direct-mapped tag/state storage, two read ports, one write port
module coh_line_state_array
  import coh_pkg::*;
#(
  parameter int LINES = 64,
  parameter int TAG_W = 20,
  localparam int IDX_W = $clog2(LINES)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [IDX_W-1:0] core_idx,
  output logic [TAG_W-1:0] core_tag,
  output logic [1:0]       core_state,
  input  logic [IDX_W-1:0] inv_idx,
  output logic [TAG_W-1:0] inv_tag,
  output logic [1:0]       inv_state,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [1:0]       wr_state
);

  logic [TAG_W-1:0] tags   [LINES];
  logic [1:0]       states [LINES];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < LINES; i++) begin
        tags[i]   <= '0;
        states[i] <= COH_I;
      end
    end else if (wr_en) begin
      tags[wr_idx]   <= wr_tag;
      states[wr_idx] <= wr_state;
    end
  end

  assign core_tag   = tags[core_idx];
  assign core_state = states[core_idx];
  assign inv_tag    = tags[inv_idx];
  assign inv_state  = states[inv_idx];

endmodule

// File: rtl/l1_coherence_agent.sv
// rtl/l1_coherence_agent.sv - per-CU requester-side I/S/M coherence controller
module l1_coherence_agent
  import coh_pkg::*;
#(
  parameter int CU_ID   = 0,
  parameter int NUM_CU  = 16,
  parameter int ADDR_W  = 32,
  parameter int LINES   = 64,
  parameter int TIMEOUT = 255
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      core_valid,
  output logic                      core_ready,
  input  logic                      core_is_write,
  input  logic [ADDR_W-1:0]         core_addr,
  output logic                      core_done,
  output logic                      core_hit,
  output logic                      dir_req_valid,
  output logic [1:0]                dir_req_type,
  output logic [ADDR_W-1:0]         dir_req_addr,
  output logic [$clog2(NUM_CU)-1:0] dir_req_cu,
  input  logic                      dir_resp_valid,
  input  logic [1:0]                dir_resp_state,
  input  logic [NUM_CU-1:0]         dir_resp_sharers,
  input  logic                      inv_valid,
  output logic                      inv_ready,
  input  logic [ADDR_W-1:0]         inv_addr,
  output logic                      inv_ack,
  output logic                      inv_dirty,
  output logic                      err_timeout,
  output logic                      err_sharer
);

  localparam int IDX_W = $clog2(LINES);
  localparam int TAG_W = ADDR_W - IDX_W - LINE_OFF;
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam int CU_W  = $clog2(NUM_CU);

  fsm_state_t       state;
  logic [CNT_W-1:0] wait_cnt;

  logic [IDX_W-1:0] core_idx, inv_idx, pend_idx, wr_idx;
  logic [TAG_W-1:0] core_tag, inv_tag, pend_tag, wr_tag;
  logic [TAG_W-1:0] core_line_tag, inv_line_tag;
  logic [1:0]       core_line_state, inv_line_state, wr_state;
  logic             wr_en, install, inv_fire, inv_match, core_fire, lookup_hit, granted;
  logic             unused_bits;

  assign core_idx = core_addr[IDX_W+LINE_OFF-1:LINE_OFF];
  assign core_tag = core_addr[ADDR_W-1:IDX_W+LINE_OFF];
  assign inv_idx  = inv_addr[IDX_W+LINE_OFF-1:LINE_OFF];
  assign inv_tag  = inv_addr[ADDR_W-1:IDX_W+LINE_OFF];
  // The latched request address doubles as the pending-line register.
  assign pend_idx = dir_req_addr[IDX_W+LINE_OFF-1:LINE_OFF];
  assign pend_tag = dir_req_addr[ADDR_W-1:IDX_W+LINE_OFF];

  assign dir_req_cu = CU_W'(CU_ID);
  assign granted    = (dir_resp_state == COH_S) || (dir_resp_state == COH_M);

  assign core_ready = !reset && (state == ST_IDLE) && !inv_valid;
  assign inv_ready  = !reset && !((state == ST_WAIT) && dir_resp_valid);
  assign core_fire  = core_valid && core_ready;
  assign inv_fire   = inv_valid && inv_ready;

  assign lookup_hit = (core_line_tag == core_tag) &&
                      ((core_line_state == COH_M) ||
                       (core_line_state == COH_S && !core_is_write));
  assign inv_match  = (inv_line_tag == inv_tag) && (inv_line_state != COH_I);

  // Install and invalidate never coincide: inv_ready drops on a response cycle.
  assign install  = (state == ST_WAIT) && dir_resp_valid && granted;
  assign wr_en    = install || (inv_fire && inv_match);
  assign wr_idx   = install ? pend_idx : inv_idx;
  assign wr_tag   = install ? pend_tag : inv_line_tag;
  assign wr_state = install ? dir_resp_state : COH_I;

  assign unused_bits = ^{core_addr[LINE_OFF-1:0], inv_addr[LINE_OFF-1:0], dir_resp_sharers};

  coh_line_state_array #(
    .LINES (LINES),
    .TAG_W (TAG_W)
  ) u_array (
    .clk        (clk),
    .reset      (reset),
    .core_idx   (core_idx),
    .core_tag   (core_line_tag),
    .core_state (core_line_state),
    .inv_idx    (inv_idx),
    .inv_tag    (inv_line_tag),
    .inv_state  (inv_line_state),
    .wr_en      (wr_en),
    .wr_idx     (wr_idx),
    .wr_tag     (wr_tag),
    .wr_state   (wr_state)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= ST_IDLE;
      wait_cnt      <= '0;
      core_done     <= 1'b0;
      core_hit      <= 1'b0;
      dir_req_valid <= 1'b0;
      dir_req_type  <= REQ_READ;
      dir_req_addr  <= '0;
      inv_ack       <= 1'b0;
      inv_dirty     <= 1'b0;
      err_timeout   <= 1'b0;
      err_sharer    <= 1'b0;
    end else begin
      core_done     <= 1'b0;
      core_hit      <= 1'b0;
      dir_req_valid <= 1'b0;
      inv_ack       <= inv_fire;
      inv_dirty     <= inv_fire && inv_match && (inv_line_state == COH_M);
      case (state)
        ST_IDLE: begin
          if (core_fire) begin
            if (lookup_hit) begin
              core_done <= 1'b1;
              core_hit  <= 1'b1;
            end else begin
              dir_req_valid <= 1'b1;
              dir_req_type  <= core_is_write ? REQ_WRITE : REQ_READ;
              dir_req_addr  <= {core_addr[ADDR_W-1:LINE_OFF], {LINE_OFF{1'b0}}};
              state         <= ST_REQ;
            end
          end
        end
        ST_REQ: begin
          wait_cnt <= '0;
          state    <= ST_WAIT;
        end
        ST_WAIT: begin
          if (dir_resp_valid) begin
            if (granted) begin
              if (!dir_resp_sharers[CU_ID]) err_sharer <= 1'b1;
              core_done <= 1'b1;
              state     <= ST_IDLE;
            end else begin
              dir_req_valid <= 1'b1;
              state         <= ST_REQ;
            end
          end else if (wait_cnt == CNT_W'(TIMEOUT)) begin
            err_timeout <= 1'b1;
            core_done   <= 1'b1;
            state       <= ST_IDLE;
          end else begin
            wait_cnt <= wait_cnt + 1'b1;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_l1_coherence_agent.sv
// tb/tb_l1_coherence_agent.sv - directed vector bench for l1_coherence_agent
module tb_l1_coherence_agent;

  logic        clk = 1'b0;
  logic        reset;
  logic        core_valid, core_ready, core_is_write, core_done, core_hit;
  logic [31:0] core_addr;
  logic        dir_req_valid;
  logic [1:0]  dir_req_type;
  logic [31:0] dir_req_addr;
  logic [3:0]  dir_req_cu;
  logic        dir_resp_valid;
  logic [1:0]  dir_resp_state;
  logic [15:0] dir_resp_sharers;
  logic        inv_valid, inv_ready, inv_ack, inv_dirty;
  logic [31:0] inv_addr;
  logic        err_timeout, err_sharer;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  l1_coherence_agent dut (
    .clk              (clk),
    .reset            (reset),
    .core_valid       (core_valid),
    .core_ready       (core_ready),
    .core_is_write    (core_is_write),
    .core_addr        (core_addr),
    .core_done        (core_done),
    .core_hit         (core_hit),
    .dir_req_valid    (dir_req_valid),
    .dir_req_type     (dir_req_type),
    .dir_req_addr     (dir_req_addr),
    .dir_req_cu       (dir_req_cu),
    .dir_resp_valid   (dir_resp_valid),
    .dir_resp_state   (dir_resp_state),
    .dir_resp_sharers (dir_resp_sharers),
    .inv_valid        (inv_valid),
    .inv_ready        (inv_ready),
    .inv_addr         (inv_addr),
    .inv_ack          (inv_ack),
    .inv_dirty        (inv_dirty),
    .err_timeout      (err_timeout),
    .err_sharer       (err_sharer)
  );

  typedef struct {
    logic        cv;
    logic        cw;
    logic [31:0] ca;
    logic        iv;
    logic [31:0] ia;
    logic        rv;
    logic [1:0]  rs;
    logic [15:0] sh;
    logic        e_cr;
    logic        e_ir;
    logic        e_done;
    logic        e_hit;
    logic        e_rqv;
    logic [1:0]  e_rqt;
    logic [31:0] e_rqa;
    logic        e_ack;
    logic        e_dirty;
  } vec_t;

  vec_t vq[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic cv, input logic cw, input logic [31:0] ca,
                       input logic iv, input logic [31:0] ia,
                       input logic rv, input logic [1:0] rs, input logic [15:0] sh);
    core_valid = cv; core_is_write = cw; core_addr = ca;
    inv_valid = iv; inv_addr = ia;
    dir_resp_valid = rv; dir_resp_state = rs; dir_resp_sharers = sh;
  endtask

  task automatic add(input logic cv, input logic cw, input logic [31:0] ca,
                     input logic iv, input logic [31:0] ia,
                     input logic rv, input logic [1:0] rs,
                     input logic e_cr, input logic e_ir, input logic e_done, input logic e_hit,
                     input logic e_rqv, input logic [1:0] e_rqt, input logic [31:0] e_rqa,
                     input logic e_ack, input logic e_dirty);
    vq.push_back('{cv, cw, ca, iv, ia, rv, rs, 16'h0001,
                   e_cr, e_ir, e_done, e_hit, e_rqv, e_rqt, e_rqa, e_ack, e_dirty});
  endtask

  initial begin
    int k;
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    reset = 1'b1;

    //   cv cw addr       iv addr      rv rs  cr ir dn ht rqv t  rqa        ack drt
    add(1, 0, 32'h1000, 0, 0,         0, 0,  1, 1, 0, 0, 1,  0, 32'h1000, 0,  0);
    add(0, 0, 0,        0, 0,         0, 0,  0, 1, 0, 0, 0,  0, 0,        0,  0);
    add(0, 0, 0,        0, 0,         1, 1,  0, 0, 1, 0, 0,  0, 0,        0,  0);
    add(1, 0, 32'h1000, 0, 0,         0, 0,  1, 1, 1, 1, 0,  0, 0,        0,  0);
    add(1, 1, 32'h1000, 0, 0,         0, 0,  1, 1, 0, 0, 1,  1, 32'h1000, 0,  0);
    add(0, 0, 0,        0, 0,         0, 0,  0, 1, 0, 0, 0,  0, 0,        0,  0);
    add(0, 0, 0,        0, 0,         1, 2,  0, 0, 1, 0, 0,  0, 0,        0,  0);
    add(1, 1, 32'h1004, 0, 0,         0, 0,  1, 1, 1, 1, 0,  0, 0,        0,  0);
    add(0, 0, 0,        1, 32'h1000,  0, 0,  0, 1, 0, 0, 0,  0, 0,        1,  1);
    add(1, 0, 32'h1000, 0, 0,         0, 0,  1, 1, 0, 0, 1,  0, 32'h1000, 0,  0);
    add(0, 0, 0,        0, 0,         0, 0,  0, 1, 0, 0, 0,  0, 0,        0,  0);
    add(0, 0, 0,        0, 0,         1, 1,  0, 0, 1, 0, 0,  0, 0,        0,  0);
    add(1, 0, 32'h1000, 1, 32'h1000,  0, 0,  0, 1, 0, 0, 0,  0, 0,        1,  0);
    add(1, 0, 32'h1000, 0, 0,         0, 0,  1, 1, 0, 0, 1,  0, 32'h1000, 0,  0);
    add(0, 0, 0,        0, 0,         0, 0,  0, 1, 0, 0, 0,  0, 0,        0,  0);
    add(0, 0, 0,        0, 0,         1, 1,  0, 0, 1, 0, 0,  0, 0,        0,  0);
    add(0, 0, 0,        1, 32'h2000,  0, 0,  0, 1, 0, 0, 0,  0, 0,        1,  0);
    add(1, 0, 32'h1000, 0, 0,         0, 0,  1, 1, 1, 1, 0,  0, 0,        0,  0);
    add(1, 0, 32'h3040, 0, 0,         0, 0,  1, 1, 0, 0, 1,  0, 32'h3040, 0,  0);
    add(0, 0, 0,        0, 0,         0, 0,  0, 1, 0, 0, 0,  0, 0,        0,  0);
    add(0, 0, 0,        0, 0,         1, 2,  0, 0, 1, 0, 0,  0, 0,        0,  0);
    add(1, 1, 32'h3044, 0, 0,         0, 0,  1, 1, 1, 1, 0,  0, 0,        0,  0);
    add(1, 1, 32'h4080, 0, 0,         0, 0,  1, 1, 0, 0, 1,  1, 32'h4080, 0,  0);
    add(0, 0, 0,        0, 0,         0, 0,  0, 1, 0, 0, 0,  0, 0,        0,  0);
    add(0, 0, 0,        1, 32'h4080,  0, 0,  0, 1, 0, 0, 0,  0, 0,        1,  0);
    add(0, 0, 0,        0, 0,         1, 2,  0, 0, 1, 0, 0,  0, 0,        0,  0);
    add(1, 1, 32'h4080, 0, 0,         0, 0,  1, 1, 1, 1, 0,  0, 0,        0,  0);

    tick();
    tick();
    chk("rst_core_ready", core_ready, 0);
    chk("rst_inv_ready", inv_ready, 0);
    chk("rst_outputs", {core_done, core_hit, dir_req_valid, dir_req_type, inv_ack, inv_dirty,
                        err_timeout, err_sharer}, 0);
    chk("rst_req_addr", dir_req_addr, 0);
    chk("req_cu", dir_req_cu, 0);
    reset = 1'b0;

    foreach (vq[i]) begin
      drive(vq[i].cv, vq[i].cw, vq[i].ca, vq[i].iv, vq[i].ia, vq[i].rv, vq[i].rs, vq[i].sh);
      #1;
      chk($sformatf("v%0d_core_ready", i), core_ready, vq[i].e_cr);
      chk($sformatf("v%0d_inv_ready", i), inv_ready, vq[i].e_ir);
      tick();
      chk($sformatf("v%0d_done_hit", i), {core_done, core_hit}, {vq[i].e_done, vq[i].e_hit});
      chk($sformatf("v%0d_req_valid", i), dir_req_valid, vq[i].e_rqv);
      if (vq[i].e_rqv)
        chk($sformatf("v%0d_req_type_addr", i), {dir_req_type, dir_req_addr[29:0]},
            {vq[i].e_rqt, vq[i].e_rqa[29:0]});
      chk($sformatf("v%0d_inv_ack_dirty", i), {inv_ack, inv_dirty}, {vq[i].e_ack, vq[i].e_dirty});
    end
    chk("no_err_after_table", {err_timeout, err_sharer}, 0);

    // Retry on a state-0 grant, then an inconsistent sharer vector.
    drive(1, 0, 32'h5000, 0, 0, 0, 0, 0);
    tick();
    chk("retry_first_req", dir_req_valid, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 0, 16'h0001);
    tick();
    chk("retry_second_req", {dir_req_valid, core_done}, 2'b10);
    chk("retry_addr", dir_req_addr, 32'h5000);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    drive(0, 0, 0, 0, 0, 1, 1, 16'hFFFE);
    tick();
    chk("sharer_done", {core_done, core_hit}, 2'b10);
    chk("sharer_err", err_sharer, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    chk("sharer_sticky", err_sharer, 1);

    // Directory never answers.
    drive(1, 0, 32'h6000, 0, 0, 0, 0, 0);
    tick();
    chk("to_req", dir_req_valid, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    k = 0;
    while (!core_done && k < 400) begin
      tick();
      k++;
    end
    chk("to_latency", k, 257);
    chk("to_err_hit", {err_timeout, core_hit}, 2'b10);
    chk("to_idle_ready", core_ready, 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("to_reset_clears", {err_timeout, err_sharer}, 0);

    // Reset abandons an in-flight miss; lines start out I again.
    drive(1, 0, 32'h1000, 0, 0, 0, 0, 0);
    tick();
    chk("post_rst_miss", dir_req_valid, 1);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();
    reset = 1'b1;
    tick();
    chk("mid_rst_quiet", {core_done, dir_req_valid, inv_ack}, 0);
    reset = 1'b0;
    drive(0, 0, 0, 0, 0, 1, 1, 16'h0001);
    tick();
    chk("mid_rst_no_done", core_done, 0);
    drive(0, 0, 0, 0, 0, 0, 0, 0);
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/l1_coherence_agent.md
# l1_coherence_agent

Per-CU requester-side coherence controller: it sits between one CU's L1 miss path and the shared directory. It tracks I/S/M state for the lines held locally and issues Read/Write requests to the directory on misses and S→M upgrades. It installs the state the directory grants and services directory-initiated invalidations with an acknowledgement. One agent is instantiated per CU, and `CU_ID` drives the directory's requester-id field.

## Interface
- `CU_ID`, 0: requester id presented to the directory.
- `NUM_CU`, 16: number of CUs; sets the id width `$clog2(NUM_CU)`.
- `ADDR_W`, 32: byte address width.
- `LINES`, 64: direct-mapped local state entries (power of two).
- `TIMEOUT`, 255: cycles `WAIT` tolerates without a directory response.

Ports (name, direction, width, meaning):
- `clk` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `core_valid` in 1: core request.
- `core_ready` out 1: request accepted when `core_valid & core_ready`.
- `core_is_write` in 1: 1 = store, 0 = load.
- `core_addr` in ADDR_W: byte address.
- `core_done` out 1: one-cycle completion pulse.
- `core_hit` out 1: valid with `core_done`; 1 = served locally.
- `dir_req_valid` out 1: one-cycle request pulse.
- `dir_req_type` out 2: 0 = Read, 1 = Write.
- `dir_req_addr` out ADDR_W: line-aligned address (bits [5:0] = 0).
- `dir_req_cu` out `$clog2(NUM_CU)`: constant `CU_ID`.
- `dir_resp_valid` in 1: directory response.
- `dir_resp_state` in 2: granted state, 0 = I, 1 = S, 2 = M.
- `dir_resp_sharers` in NUM_CU: sharer vector; only a CU_ID-bit consistency check uses it.
- `inv_valid` in 1: invalidation request.
- `inv_ready` out 1: invalidation accepted when `inv_valid & inv_ready`.
- `inv_addr` in ADDR_W: line to invalidate.
- `inv_ack` out 1: one-cycle pulse, the cycle after acceptance.
- `inv_dirty` out 1: valid with `inv_ack`; 1 = the line was M.
- `err_timeout` out 1: sticky; cleared only by reset.
- `err_sharer` out 1: sticky; response granted S/M but `dir_resp_sharers[CU_ID]` = 0.

## Operation
- Line geometry:
  - 64-byte lines.
  - Index = `addr[$clog2(LINES)+5:6]`.
  - Tag = `addr[ADDR_W-1:$clog2(LINES)+6]`.
  - Per-entry storage is a tag plus a 2-bit state.
- FSM states: IDLE, REQ, WAIT.
- IDLE:
  - `core_ready` = !`inv_valid`, so an invalidation has priority over a core request in the same cycle.
  - On an accepted core request, the lookup is combinational.
  - Hit cases: a load hits on tag match with state S or M; a store hits on tag match with state M.
  - On a hit, `core_done=1` and `core_hit=1` the next cycle; the FSM stays in IDLE.
  - Otherwise latch the address and type, then go to REQ. A store to an S line is an upgrade (type 1).
- REQ: drive `dir_req_valid=1` for exactly one cycle with the latched type and line address; then go to WAIT and clear the timeout counter.
- WAIT, on `dir_resp_valid`:
  - Granted state 1 or 2: write the tag and the granted state into the entry. A prior occupant is silently replaced (the directory is responsible for tracking it). Pulse `core_done` with `core_hit=0` and go to IDLE.
  - Granted state 0: return to REQ and retry without limit.
  - Granted state 2 on a Read request is legal and is installed as M.
- WAIT timeout: when the counter reaches `TIMEOUT`, set `err_timeout`, pulse `core_done` (`core_hit=0`), install nothing and go to IDLE.
- Invalidations:
  - `inv_ready`=1 in every state except a WAIT cycle with `dir_resp_valid`=1, which is a single write-port conflict.
  - On acceptance with tag match and state ≠ I: set the entry to I, and set `inv_dirty` = (old state == M).
  - No match: the entry is unchanged and `inv_dirty=0`.
  - `inv_ack` is always pulsed the following cycle.
  - An invalidation accepted in WAIT to the pending line has no effect on the later install.

## Timing
- Reset: all entries I; FSM to IDLE; `core_ready`, `core_done`, `core_hit`, `dir_req_valid`, `dir_req_type`, `dir_req_addr`, `inv_ready`, `inv_ack`, `inv_dirty` = 0; `err_*` = 0. `reset` asserted mid-transaction abandons it with no `core_done`.
- Hit latency: 1 cycle, accept to `core_done`.
- Miss latency: accept in cycle 0, `dir_req_valid` in cycle 1, response in cycle n ≥ 2, `core_done` in cycle n+1.
- At most one outstanding directory request; `core_ready`=0 outside IDLE.
- All outputs are registered except `core_ready` and `inv_ready`.

## Structure
- Shared package `coh_pkg` holds:
  - State encodings `COH_I`=0, `COH_S`=1, `COH_M`=2.
  - Request types `REQ_READ`=0, `REQ_WRITE`=1.
  - `LINE_OFF`=6.
  - The FSM state enum.
- Sub-module `coh_line_state_array`: tag and state storage with one combinational read port for the core, one for invalidation, and one write port; cleared on reset.

## Test plan
- Load to 0x1000 after reset → `dir_req_valid` with type 0, address 0x1000; respond state 1 with sharer bit set → `core_done`, `core_hit=0`; a repeat load gives `core_hit=1` one cycle after accept with no `dir_req_valid`.
- Store to S line 0x1000 → upgrade request type 1; respond state 2 → a later store to 0x1004 hits.
- `inv_valid` at 0x1000 while the line is in M → `inv_ack=1`, `inv_dirty=1` the next cycle; a subsequent load misses.
- `core_valid` and `inv_valid` in the same IDLE cycle → `core_ready=0`, the invalidation is serviced first, and the core request is accepted the next cycle.
- Response with state 0 → a second `dir_req_valid` follows; a state 1 response with `dir_resp_sharers[CU_ID]=0` sets `err_sharer`.
- No response for 255 cycles → `err_timeout=1`, `core_done` pulses, the FSM returns to IDLE, and a `reset` pulse clears `err_timeout`.
